ysyx_22040125_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV64 core. It steps each instruction through fetch, decode, execute, optional memory access and writeback, and drives the instruction-memory and data-memory request handshakes. It gates the PC, IR and register-file write enables using the decoder's control outputs. It sits between the instruction decoder (data_ren, data_wen, reg_wen, ebreak) and the PC, IR, register-file and memory interfaces. It also counts retired instructions.

---
 rtl/ysyx_22040125_seq_ctrl.sv | 107 ++++++++++
 tb/tb_ysyx_22040125_seq_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
// Optional memory-wait watchdog enabled by YSYX_22040125_SEQ_WATCHDOG_EN.
module ysyx_22040125_seq_ctrl #(
  parameter int WDT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_data_ren,
  input  logic        dec_data_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_ebreak,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t cur, nxt;
  logic   wdt_expire;
  logic   is_load;

  // A combined load+store is handled as a store, so it gets no implicit rd write.
  assign is_load = dec_data_ren && !dec_data_wen;

`ifdef YSYX_22040125_SEQ_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_cnt;
  logic             waiting;

  assign waiting    = ((cur == S_FETCH) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);
  assign wdt_expire = waiting && (wdt_cnt == {WDT_W{1'b1}});

  // Any cycle outside a wait clears the count, which covers every entry to FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wdt_cnt <= '0;
    else if (waiting) wdt_cnt <= wdt_cnt + 1'b1;
    else              wdt_cnt <= '0;
  end
`else
  assign wdt_expire = 1'b0 && (WDT_W > 0);
`endif

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  if (imem_ready) nxt = S_DECODE;
                else if (wdt_expire) nxt = S_HALT;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   if (dec_ebreak) nxt = S_HALT;
                else if (dec_data_wen || dec_data_ren) nxt = S_MEM;
                else nxt = S_WB;
      S_MEM:    if (dmem_ready) nxt = S_WB;
                else if (wdt_expire) nxt = S_HALT;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_HALT;
    endcase
  end

  // Strobes are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_IDLE;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      reg_we   <= 1'b0;
      pc_we    <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      instret  <= 64'd0;
    end else begin
      cur      <= nxt;
      imem_req <= (nxt == S_FETCH);
      dmem_req <= (nxt == S_MEM);
      dmem_we  <= (nxt == S_MEM) && dec_data_wen;
      reg_we   <= (nxt == S_WB) && (dec_reg_wen || is_load);
      pc_we    <= (nxt == S_WB);
      halted   <= (nxt == S_HALT);
      if (wdt_expire) err <= 1'b1;
      if (cur == S_WB) instret <= instret + 64'd1;
    end
  end

  assign ir_we = (cur == S_FETCH) && imem_ready;
  assign state = cur;

endmodule

// File: tb/tb_ysyx_22040125_seq_ctrl.sv
// Randomized bench for ysyx_22040125_seq_ctrl: builds the expected per-cycle trace of
// each instruction from its kind and wait counts, and checks the DUT cycle by cycle.
module tb_ysyx_22040125_seq_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3, K_BOTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_ready, dmem_ready;
  logic        dec_data_ren, dec_data_wen, dec_reg_wen, dec_ebreak;
  logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, err;
  logic [2:0]  state;
  logic [63:0] instret;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] m_instret = 64'd0;

  ysyx_22040125_seq_ctrl #(.WDT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_data_ren(dec_data_ren), .dec_data_wen(dec_data_wen),
    .dec_reg_wen(dec_reg_wen), .dec_ebreak(dec_ebreak),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_we(reg_we), .pc_we(pc_we), .halted(halted), .err(err),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle in expected state st. rdy drives the ready input matching st; the
  // other ready input and start (outside IDLE) are random noise that must be ignored.
  task automatic cyc(input logic [2:0] st, input logic rdy, input logic go,
                     input logic e_dwe, input logic e_rwe, input logic e_err);
    logic [10:0] got, exp;
    start      = (st == ST_IDLE)  ? go  : 1'($urandom);
    imem_ready = (st == ST_FETCH) ? rdy : 1'($urandom);
    dmem_ready = (st == ST_MEM)   ? rdy : 1'($urandom);
    @(negedge clk);
    got = {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, err};
    exp = {st, st == ST_FETCH, (st == ST_FETCH) && rdy, st == ST_MEM, e_dwe, e_rwe,
           st == ST_WB, st == ST_HALT, e_err};
    check_eq($sformatf("ctrl st%0d {state,ireq,irwe,dreq,dwe,rwe,pcwe,halt,err}", st), 64'(got), 64'(exp));
    check_eq($sformatf("instret st%0d", st), instret, m_instret);
    @(posedge clk); #1;
    if (st == ST_WB) m_instret = m_instret + 64'd1;
  endtask

  // Expected trace of one instruction: FETCH x(fw+1), DECODE, EXEC, [MEM x(mw+1)], WB.
  task automatic do_instr(input int kind, input int fw, input int mw, input logic rw);
    logic is_mem, is_store;
    dec_data_ren = (kind == K_LOAD)  || (kind == K_BOTH);
    dec_data_wen = (kind == K_STORE) || (kind == K_BOTH);
    dec_ebreak   = (kind == K_EBREAK);
    dec_reg_wen  = rw;
    is_mem   = dec_data_ren || dec_data_wen;
    is_store = dec_data_wen;
    for (int i = 0; i <= fw; i++) cyc(ST_FETCH, i == fw, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ST_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (kind != K_EBREAK) begin
      if (is_mem)
        for (int j = 0; j <= mw; j++) cyc(ST_MEM, j == mw, 1'b0, is_store, 1'b0, 1'b0);
      cyc(ST_WB, 1'b0, 1'b0, 1'b0, rw || (kind == K_LOAD), 1'b0);
    end
  endtask

  task automatic apply_reset();
    logic [10:0] got;
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, err};
      check_eq("reset outputs", 64'(got), 64'd0);
      check_eq("reset instret", instret, 64'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    m_instret = 64'd0;
    cyc(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic kick();
    cyc(ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_data_ren = 1'b0; dec_data_wen = 1'b0; dec_reg_wen = 1'b0; dec_ebreak = 1'b0;
    @(posedge clk); #1;
    apply_reset();
    cyc(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    kick();

    do_instr(K_ALU, 0, 0, 1'b1);
    do_instr(K_LOAD, 0, 3, 1'b0);
    do_instr(K_STORE, 1, 0, 1'b0);
    do_instr(K_BOTH, 0, 1, 1'b0);
    do_instr(K_ALU, 2, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int k;
      k = int'($urandom_range(0, 3));
      do_instr((k == 3) ? K_BOTH : k, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom));
    end

    // ebreak halts without retiring; everything afterwards is ignored.
    do_instr(K_EBREAK, 1, 0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(ST_HALT, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while a load waits in MEM drops dmem_req without a clock edge.
    apply_reset();
    kick();
    do_instr(K_ALU, 0, 0, 1'b1);
    dec_data_ren = 1'b1; dec_data_wen = 1'b0; dec_ebreak = 1'b0; dec_reg_wen = 1'b0;
    cyc(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ST_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ST_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    @(negedge clk);
    check_eq("mid-mem dmem_req before reset", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid-mem dmem_req async", 64'(dmem_req), 64'd0);
    check_eq("mid-mem state async", 64'(state), 64'(ST_IDLE));
    check_eq("mid-mem instret async", instret, 64'd0);
    @(posedge clk); #1;
    apply_reset();
    kick();

`ifdef YSYX_22040125_SEQ_WATCHDOG_EN
    for (int i = 0; i < 16; i++) cyc(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ST_HALT, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 120; i++) cyc(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
